// File: rtl/memory_access_stage_pkg.sv
// Shared Y86-64 constants for the memory stage: icodes, status codes and FSM states.
package memory_access_stage_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/memory_access_stage_watchdog.sv
// Bus watchdog: counts REQ cycles and flags expiry on the TIMEOUT-th cycle without ack.
module memory_access_stage_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // Count enabled cycles; clear restarts the window for the next access.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Expire during the cycle that would be the TIMEOUT-th enabled cycle.
  assign o_expire = i_en && (r_count == LAST);

endmodule

// File: rtl/memory_access_stage.sv
// Y86-64 memory stage: data-memory access over req/ack with watchdog, producing m_valM and m_stat.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass through, in-range access launches
// REQ   | bus request held until ack or watchdog expiry
// DONE  | access finished; m_valM/m_stat valid for the W register
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int MEM_BYTES = 8192,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  M_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] M_valA_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic        mem_err_i,
  input  logic [63:0] mem_rdata_i,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic        m_busy_o
);

  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  mem_state_e  r_state;
  logic        r_req;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_fault;
  logic [63:0] r_rdata;

  logic        w_is_read;
  logic        w_is_write;
  logic        w_need;
  logic [63:0] w_addr;
  logic        w_in_range;
  logic        w_start;
  logic        w_adr_fault;
  logic        w_expire;

  // Decode the instruction in M into access type, address and launch/fault conditions.
  always_comb begin
    w_is_read   = (M_icode_i == IMRMOVQ) || (M_icode_i == IPOPQ) || (M_icode_i == IRET);
    w_is_write  = (M_icode_i == IRMMOVQ) || (M_icode_i == IPUSHQ) || (M_icode_i == ICALL);
    w_addr      = ((M_icode_i == IPOPQ) || (M_icode_i == IRET)) ? M_valA_i : M_valE_i;
    w_need      = (M_stat_i == SAOK) && (w_is_read || w_is_write);
    w_in_range  = (w_addr <= ADDR_MAX);
    w_start     = (r_state == IDLE) && w_need && w_in_range;
    w_adr_fault = (r_state == IDLE) && w_need && !w_in_range;
  end

  memory_access_stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .i_clr    (r_state == IDLE),
    .i_en     (r_state == REQ),
    .o_expire (w_expire)
  );

  // Access FSM with registered bus outputs; ack wins over a same-cycle watchdog expiry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_fault <= 1'b0;
      r_rdata <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_we    <= w_is_write;
            r_addr  <= w_addr;
            r_wdata <= M_valA_i;
            r_fault <= 1'b0;
            r_rdata <= 64'd0;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            if (!r_we) begin
              r_rdata <= mem_rdata_i;
            end
            r_fault <= mem_err_i;
            r_req   <= 1'b0;
            r_state <= DONE;
          end else if (w_expire) begin
            r_fault <= 1'b1;
            r_req   <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

  // Stage results: busy while launching or waiting; SADR on range or bus fault.
  always_comb begin
    m_busy_o = w_start || (r_state == REQ);
    m_valM_o = ((r_state == DONE) && !r_we) ? r_rdata : 64'd0;
    m_stat_o = M_stat_i;
    if (w_adr_fault || ((r_state == DONE) && r_fault)) begin
      m_stat_o = SADR;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: vector table + scoreboard, plus reset/stray-ack sequences.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  localparam int MEMB = 8192;
  localparam int TMO  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE, M_valA;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack, mem_err;
  logic [63:0] mem_rdata;
  logic [63:0] m_valM;
  logic [2:0]  m_stat;
  logic        m_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.MEM_BYTES(MEMB), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .M_stat_i(M_stat), .M_icode_i(M_icode), .M_valE_i(M_valE), .M_valA_i(M_valA),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_err_i(mem_err), .mem_rdata_i(mem_rdata),
    .m_valM_o(m_valM), .m_stat_o(m_stat), .m_busy_o(m_busy)
  );

  typedef struct {
    string       name;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] valE;
    logic [63:0] valA;
    int          ack_at;   // REQ cycle on which ack is driven; 0 = never
    logic        err;
    logic [63:0] rdata;
    int          e_busy;
    int          e_req;
    logic        e_we;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [63:0] e_valM;
    logic [2:0]  e_stat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(string name, logic [3:0] icode, logic [2:0] stat,
                              logic [63:0] valE, logic [63:0] valA, int ack_at,
                              logic err, logic [63:0] rdata, int e_busy, int e_req,
                              logic e_we, logic [63:0] e_addr, logic [63:0] e_wdata,
                              logic [63:0] e_valM, logic [2:0] e_stat);
    vec_t v;
    v.name = name; v.icode = icode; v.stat = stat; v.valE = valE; v.valA = valA;
    v.ack_at = ack_at; v.err = err; v.rdata = rdata; v.e_busy = e_busy; v.e_req = e_req;
    v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_valM = e_valM; v.e_stat = e_stat;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_m(logic [3:0] icode, logic [2:0] stat, logic [63:0] valE, logic [63:0] valA);
    M_icode = icode; M_stat = stat; M_valE = valE; M_valA = valA;
  endtask

  // Drive one instruction, play the bus responder, and compare against the scoreboard at output time.
  task automatic run_vec(vec_t v);
    int   busy_cnt, req_cnt, cyc;
    bit   finished, seen_req;
    vec_t e;
    sb.push_back(v);
    set_m(v.icode, v.stat, v.valE, v.valA);
    busy_cnt = 0; req_cnt = 0; cyc = 0; finished = 0; seen_req = 0;
    while (!finished) begin
      @(negedge clk);
      cyc++;
      if (cyc > 300) begin
        errors++; checks++;
        $display("FAIL %s timeout: no output after %0d cycles", v.name, cyc);
        void'(sb.pop_front());
        finished = 1;
      end else if (m_busy) begin
        busy_cnt++;
        if (mem_req) begin
          req_cnt++;
          if (!seen_req) begin
            seen_req = 1;
            chk({v.name, " addr"},  mem_addr,  v.e_addr);
            chk({v.name, " we"},    {63'd0, mem_we}, {63'd0, v.e_we});
            if (v.e_we) chk({v.name, " wdata"}, mem_wdata, v.e_wdata);
          end
          if (req_cnt == v.ack_at) begin
            mem_ack = 1'b1; mem_err = v.err; mem_rdata = v.rdata;
          end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 64'd0;
      end else begin
        e = sb.pop_front();
        chk({e.name, " stat"},  {61'd0, m_stat}, {61'd0, e.e_stat});
        chk({e.name, " valM"},  m_valM, e.e_valM);
        chk({e.name, " busy_cycles"}, 64'(busy_cnt), 64'(e.e_busy));
        chk({e.name, " req_cycles"},  64'(req_cnt),  64'(e.e_req));
        chk({e.name, " req_low_out"}, {63'd0, mem_req}, 64'd0);
        finished = 1;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 64'd0;
    set_m(INOP, SAOK, 64'd0, 64'd0);

    //          name        icode    stat  valE                   valA                   ack err rdata           busy req we addr                   wdata        valM            stat
    vecs.push_back(mk("mrmovq",   IMRMOVQ, SAOK, 64'h100,              64'h0,                 1, 0, 64'hDEADBEEF, 2, 1, 0, 64'h100,              64'h0,   64'hDEADBEEF, SAOK));
    vecs.push_back(mk("pushq",    IPUSHQ,  SAOK, 64'h1F8,              64'h55,                3, 0, 64'h0,        4, 3, 1, 64'h1F8,              64'h55,  64'h0,        SAOK));
    vecs.push_back(mk("rmm_oor",  IRMMOVQ, SAOK, 64'(MEMB),            64'h9,                 0, 0, 64'h0,        0, 0, 0, 64'h0,                64'h0,   64'h0,        SADR));
    vecs.push_back(mk("popq_err", IPOPQ,   SAOK, 64'h999,              64'h200,               1, 1, 64'h1234,     2, 1, 0, 64'h200,              64'h0,   64'h1234,     SADR));
    vecs.push_back(mk("ret_tmo",  IRET,    SAOK, 64'h0,                64'h300,               0, 0, 64'h0,        5, 4, 0, 64'h300,              64'h0,   64'h0,        SADR));
    vecs.push_back(mk("nop",      INOP,    SAOK, 64'h100,              64'h100,               0, 0, 64'h0,        0, 0, 0, 64'h0,                64'h0,   64'h0,        SAOK));
    vecs.push_back(mk("mrm_shlt", IMRMOVQ, SHLT, 64'h100,              64'h0,                 0, 0, 64'h0,        0, 0, 0, 64'h0,                64'h0,   64'h0,        SHLT));
    vecs.push_back(mk("call",     ICALL,   SAOK, 64'h1000,             64'h40,                2, 0, 64'hFF,       3, 2, 1, 64'h1000,             64'h40,  64'h0,        SAOK));
    vecs.push_back(mk("mrm_top",  IMRMOVQ, SAOK, 64'(MEMB-8),          64'h0,                 1, 0, 64'hCAFE,     2, 1, 0, 64'(MEMB-8),          64'h0,   64'hCAFE,     SAOK));
    vecs.push_back(mk("mrm_oor1", IMRMOVQ, SAOK, 64'(MEMB-7),          64'h0,                 0, 0, 64'h0,        0, 0, 0, 64'h0,                64'h0,   64'h0,        SADR));
    vecs.push_back(mk("ret_huge", IRET,    SAOK, 64'h10,               64'hFFFFFFFFFFFFFFF8,  0, 0, 64'h0,        0, 0, 0, 64'h0,                64'h0,   64'h0,        SADR));
    vecs.push_back(mk("ack_tmo",  IMRMOVQ, SAOK, 64'h80,               64'h0,                 4, 0, 64'h77,       5, 4, 0, 64'h80,               64'h0,   64'h77,       SAOK));
    vecs.push_back(mk("ackerr_t", IRMMOVQ, SAOK, 64'h88,               64'hAB,                4, 1, 64'h0,        5, 4, 1, 64'h88,               64'hAB,  64'h0,        SADR));
    vecs.push_back(mk("irmovq",   IIRMOVQ, SAOK, 64'hFFFF0000,         64'h0,                 0, 0, 64'h0,        0, 0, 0, 64'h0,                64'h0,   64'h0,        SAOK));
    vecs.push_back(mk("pop_sins", IPOPQ,   SINS, 64'h0,                64'h8,                 0, 0, 64'h0,        0, 0, 0, 64'h0,                64'h0,   64'h0,        SINS));

    // Reset state
    #12;
    chk("rst req",   {63'd0, mem_req}, 64'd0);
    chk("rst we",    {63'd0, mem_we},  64'd0);
    chk("rst addr",  mem_addr,  64'd0);
    chk("rst wdata", mem_wdata, 64'd0);
    chk("rst valM",  m_valM,    64'd0);
    chk("rst busy",  {63'd0, m_busy}, 64'd0);
    chk("rst stat",  {61'd0, m_stat}, {61'd0, SAOK});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Stray ack after a timeout must be ignored while idle.
    run_vec(vecs[4]);
    set_m(INOP, SAOK, 64'h0, 64'h0);
    mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 64'h5A5A;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stray req",  {63'd0, mem_req}, 64'd0);
      chk("stray busy", {63'd0, m_busy},  64'd0);
      chk("stray stat", {61'd0, m_stat},  {61'd0, SAOK});
      chk("stray valM", m_valM, 64'd0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 64'd0;
    run_vec(vecs[0]);

    // Asynchronous reset in the middle of REQ.
    set_m(IMRMOVQ, SAOK, 64'h40, 64'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 10);
    chk("mid req seen", {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst req",  {63'd0, mem_req}, 64'd0);
    chk("arst addr", mem_addr, 64'd0);
    chk("arst busy_idle", {63'd0, m_busy}, 64'd1);
    set_m(INOP, SAOK, 64'h0, 64'h0);
    #1;
    chk("arst busy_nop", {63'd0, m_busy}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 64'h1111;
    @(negedge clk);
    chk("late ack req",  {63'd0, mem_req}, 64'd0);
    chk("late ack stat", {61'd0, m_stat}, {61'd0, SAOK});
    chk("late ack valM", m_valM, 64'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 64'd0;
    @(negedge clk);
    chk("post rst busy", {63'd0, m_busy}, 64'd0);
    chk("post rst valM", m_valM, 64'd0);
    @(posedge clk); #1;
    run_vec(vecs[1]);

    chk("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Y86-64 memory stage, directly downstream of the execute→memory pipeline register. Consumes the M-register fields, performs the data-memory read or write over a req/ack bus with a bounded-wait watchdog, and produces m_valM and the final m_stat for the memory→writeback register. Holds the pipeline through m_busy_o while an access is outstanding. Detects address and bus faults.

## Interface
- MEM_BYTES, 8192: valid data-address range is [0, MEM_BYTES-8]; any other address faults.
- TIMEOUT, 64: maximum REQ cycles without ack before the access faults; range 1..255.
- clk_i  in  1  sole clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- M_stat_i, M_icode_i, M_valE_i, M_valA_i  in  3/4/64/64  fields from the M pipeline register.
- mem_req_o  out  1  bus request, held until ack.
- mem_we_o  out  1  1 = write, 0 = read; valid with req.
- mem_addr_o, mem_wdata_o  out  64/64  address and write data; valid with req.
- mem_ack_i  in  1  one-cycle completion strobe.
- mem_err_i  in  1  bus error; sampled only with ack.
- mem_rdata_i  in  64  read data; sampled only with ack.
- m_valM_o  out  64  read result.
- m_stat_o  out  3  stage status to writeback and hazard control.
- m_busy_o  out  1  stall request to hazard control: stall F/D/E/M, bubble W.

## Operation
- Read ops: mrmovq, popq, ret.
- Write ops: rmmovq, pushq, call.
- All other icodes are no-ops for this stage.
- Address source: M_valE_i for rmmovq, pushq, call, mrmovq; M_valA_i for popq, ret.
- Write data is M_valA_i, which carries valP for call.
- An access is needed only when M_stat_i == SAOK and the icode is a read or write op.
  - If the address is out of range, no bus cycle is issued and m_stat_o = SADR.
- FSM states:
  - IDLE: when an in-range access is needed, m_busy_o = 1; next state REQ; address, data, we and a cleared watchdog are registered.
  - REQ: mem_req_o = 1 and m_busy_o = 1; watchdog increments each cycle.
    - Ack: capture mem_rdata_i (reads) and mem_err_i into a fault flag; next state DONE.
    - Watchdog reaches TIMEOUT without ack: set the fault flag; next state DONE.
  - DONE: m_busy_o = 0, mem_req_o = 0; outputs valid; next state IDLE unconditionally.
- m_stat_o:
  - Fault flag set in DONE → SADR.
  - Out-of-range address in IDLE → SADR.
  - Otherwise M_stat_i passes through.
- m_valM_o:
  - DONE after a read → the captured data.
  - All other cases → 0.
- Non-memory or non-SAOK instructions pass through in IDLE with zero added latency and m_busy_o = 0.
- mem_ack_i outside REQ is ignored.
- An ack and watchdog expiry in the same cycle resolve as an ack; the fault flag is then mem_err_i.

## Timing
- Reset values: state IDLE; mem_req_o 0; mem_we_o 0; mem_addr_o 0; mem_wdata_o 0; watchdog 0; fault flag 0; captured data 0.
- Reset values (continued): m_valM_o 0; m_busy_o is 0 as long as M_icode_i is INOP.
- Reset asserted mid-REQ drops mem_req_o immediately (asynchronous). A late ack after reset release is ignored.
- Minimum latency of an access is 3 cycles: IDLE, REQ with ack, DONE. The W register latches at the end of DONE.
- Each additional REQ cycle without ack adds one cycle.
- The M register is held stable by stall throughout IDLE(busy)/REQ, so address inputs do not change mid-access.
- The stage issues one bus request per instruction; back-to-back memory ops each re-enter IDLE.

## Structure
- Shared package `define.v` (already in the tree) supplies:
  - icode constants: INOP, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ.
  - status codes: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - RNONE.
- Add FSM state encodings IDLE/REQ/DONE to the same package.
- One sub-module is natural: mem_watchdog, a TIMEOUT-parameterised counter with clear, enable and expire.

## Test plan
- mrmovq, valE=0x100, ack on 1st REQ cycle with rdata=0xDEADBEEF → req high 1 cycle, addr=0x100, we=0; busy for 2 cycles; DONE: m_valM=0xDEADBEEF, m_stat=SAOK.
- pushq, valE=0x1F8, valA=0x55, ack after 3 REQ cycles → we=1, wdata=0x55; busy for 4 cycles; m_valM=0.
- rmmovq, valE=MEM_BYTES → mem_req_o never asserts, busy=0, m_stat=SADR in the same cycle.
- popq, valA=0x200, ack with mem_err_i=1 → m_stat=SADR in DONE.
- ret with no ack ever, TIMEOUT=4 → req for 4 cycles then dropped, DONE with m_stat=SADR; a later stray ack is ignored.
- rst_n_i low during REQ → mem_req_o=0 asynchronously, state IDLE. INOP/SHLT in M → pass-through with busy=0 and m_stat=M_stat_i.
